// File: rtl/fft4_radix2.sv
// Fixed 4-point radix-2 DIT FFT on parallel complex samples.
// Frame capture, two registered butterfly stages, then a one-cycle result strobe.
module fft4_radix2 #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NFFT   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid,
   input  logic                          clk_i_data,
   input  logic [NFFT-1:0][DATA_W-1:0]   data_in_i,
   input  logic [NFFT-1:0][DATA_W-1:0]   data_in_q,
   output logic                          clk_o_data,
   output logic [NFFT-1:0][DATA_W-1:0]   data_out_i,
   output logic [NFFT-1:0][DATA_W-1:0]   data_out_q,
   output logic                          complete,
   output logic [2:0]                    stateFFT
);

   localparam int unsigned A_W = DATA_W + 1;
   localparam int unsigned B_W = DATA_W + 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STAGE1 = 3'd1,
      STAGE2 = 3'd2,
      DONE   = 3'd3
   } state_t;

   state_t state;
   state_t next_state;
   logic   capture_c;
   logic   stage1_c;
   logic   stage2_c;

   logic signed [DATA_W-1:0] x_i [NFFT];
   logic signed [DATA_W-1:0] x_q [NFFT];
   logic signed [A_W-1:0]    a_i [NFFT];
   logic signed [A_W-1:0]    a_q [NFFT];
   logic signed [A_W-1:0]    a_i_c [NFFT];
   logic signed [A_W-1:0]    a_q_c [NFFT];
   logic signed [B_W-1:0]    y_i_c [NFFT];
   logic signed [B_W-1:0]    y_q_c [NFFT];

   // The legacy data clock is tied to clk by the integrator and carries no information.
   logic unused_clk_i_data;
   assign unused_clk_i_data = clk_i_data;

   assign stateFFT = state;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and stage strobes; unused codes fall back to IDLE
   always_comb begin
      next_state = IDLE;
      capture_c  = 1'b0;
      stage1_c   = 1'b0;
      stage2_c   = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               capture_c  = 1'b1;
               next_state = STAGE1;
            end else begin
               next_state = IDLE;
            end
         end
         STAGE1: begin
            stage1_c   = 1'b1;
            next_state = STAGE2;
         end
         STAGE2: begin
            stage2_c   = 1'b1;
            next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // First butterfly stage: pairs (x0,x2) and (x1,x3), sign-extended by one bit
   always_comb begin
      a_i_c[0] = A_W'(x_i[0]) + A_W'(x_i[2]);
      a_q_c[0] = A_W'(x_q[0]) + A_W'(x_q[2]);
      a_i_c[1] = A_W'(x_i[0]) - A_W'(x_i[2]);
      a_q_c[1] = A_W'(x_q[0]) - A_W'(x_q[2]);
      a_i_c[2] = A_W'(x_i[1]) + A_W'(x_i[3]);
      a_q_c[2] = A_W'(x_q[1]) + A_W'(x_q[3]);
      a_i_c[3] = A_W'(x_i[1]) - A_W'(x_i[3]);
      a_q_c[3] = A_W'(x_q[1]) - A_W'(x_q[3]);
   end

   // Second stage; the odd bins fold in the -j twiddle on a3 as a re/im swap
   always_comb begin
      y_i_c[0] = B_W'(a_i[0]) + B_W'(a_i[2]);
      y_q_c[0] = B_W'(a_q[0]) + B_W'(a_q[2]);
      y_i_c[2] = B_W'(a_i[0]) - B_W'(a_i[2]);
      y_q_c[2] = B_W'(a_q[0]) - B_W'(a_q[2]);
      y_i_c[1] = B_W'(a_i[1]) + B_W'(a_q[3]);
      y_q_c[1] = B_W'(a_q[1]) - B_W'(a_i[3]);
      y_i_c[3] = B_W'(a_i[1]) - B_W'(a_q[3]);
      y_q_c[3] = B_W'(a_q[1]) + B_W'(a_i[3]);
   end

   // Input capture and first-stage pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(NFFT); k++) begin
            x_i[k] <= '0;
            x_q[k] <= '0;
            a_i[k] <= '0;
            a_q[k] <= '0;
         end
      end else begin
         if (capture_c) begin
            for (int k = 0; k < int'(NFFT); k++) begin
               x_i[k] <= data_in_i[k];
               x_q[k] <= data_in_q[k];
            end
         end
         if (stage1_c) begin
            for (int k = 0; k < int'(NFFT); k++) begin
               a_i[k] <= a_i_c[k];
               a_q[k] <= a_q_c[k];
            end
         end
      end
   end

   // Result registers: low bits of the full-width sums, wrapping without saturation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_i <= '0;
         data_out_q <= '0;
         complete   <= 1'b0;
         clk_o_data <= 1'b0;
      end else begin
         clk_o_data <= stage2_c;
         if (capture_c) begin
            complete <= 1'b0;
         end
         if (stage2_c) begin
            for (int k = 0; k < int'(NFFT); k++) begin
               data_out_i[k] <= DATA_W'(y_i_c[k]);
               data_out_q[k] <= DATA_W'(y_q_c[k]);
            end
            complete <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft4_radix2.sv
// Directed-vector bench for fft4_radix2: table of frames with hand-computed bins,
// plus held-valid streaming and mid-frame reset sequences.
module tb_fft4_radix2;

   typedef logic [3:0][15:0] vec_t;

   typedef struct {
      string name;
      vec_t  xi;
      vec_t  xq;
      vec_t  ei;
      vec_t  eq;
   } frame_t;

   logic       clk;
   logic       rst;
   logic       valid;
   logic       clk_i_data;
   vec_t       data_in_i;
   vec_t       data_in_q;
   logic       clk_o_data;
   vec_t       data_out_i;
   vec_t       data_out_q;
   logic       complete;
   logic [2:0] stateFFT;

   int checks;
   int errors;

   frame_t tbl [6];

   fft4_radix2 dut (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .clk_i_data (clk_i_data),
      .data_in_i  (data_in_i),
      .data_in_q  (data_in_q),
      .clk_o_data (clk_o_data),
      .data_out_i (data_out_i),
      .data_out_q (data_out_q),
      .complete   (complete),
      .stateFFT   (stateFFT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign clk_i_data = clk;

   function automatic vec_t pk(input int v0, input int v1, input int v2, input int v3);
      vec_t r;
      r[0] = 16'(v0);
      r[1] = 16'(v1);
      r[2] = 16'(v2);
      r[3] = 16'(v3);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one frame with a single valid pulse and follow it to IDLE.
   task automatic run_frame(input frame_t f);
      @(negedge clk);
      data_in_i = f.xi;
      data_in_q = f.xq;
      valid     = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      data_in_i = pk(999, -999, 1234, -4321);
      data_in_q = pk(-7, 7, 555, -555);
      chk({f.name, " s1 state"}, 64'(stateFFT), 64'd1);
      chk({f.name, " s1 complete"}, 64'(complete), 64'd0);
      chk({f.name, " s1 strobe"}, 64'(clk_o_data), 64'd0);
      @(negedge clk);
      chk({f.name, " s2 state"}, 64'(stateFFT), 64'd2);
      chk({f.name, " s2 complete"}, 64'(complete), 64'd0);
      @(negedge clk);
      chk({f.name, " done state"}, 64'(stateFFT), 64'd3);
      chk({f.name, " done strobe"}, 64'(clk_o_data), 64'd1);
      chk({f.name, " done complete"}, 64'(complete), 64'd1);
      chk({f.name, " out_i"}, 64'(data_out_i), 64'(f.ei));
      chk({f.name, " out_q"}, 64'(data_out_q), 64'(f.eq));
      @(negedge clk);
      chk({f.name, " idle state"}, 64'(stateFFT), 64'd0);
      chk({f.name, " idle strobe"}, 64'(clk_o_data), 64'd0);
      chk({f.name, " idle complete"}, 64'(complete), 64'd1);
      chk({f.name, " hold out_i"}, 64'(data_out_i), 64'(f.ei));
      chk({f.name, " hold out_q"}, 64'(data_out_q), 64'(f.eq));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      valid     = 1'b0;
      data_in_i = '0;
      data_in_q = '0;

      tbl[0] = '{"vec1",  pk(12, 77, 15, -9),  pk(47, 78, 8, 5),
                          pk(95, 70, -41, -76), pk(138, -47, -28, 125)};
      tbl[1] = '{"impulse", pk(1, 0, 0, 0),    pk(0, 0, 0, 0),
                          pk(1, 1, 1, 1),      pk(0, 0, 0, 0)};
      tbl[2] = '{"dc100", pk(100, 100, 100, 100), pk(0, 0, 0, 0),
                          pk(400, 0, 0, 0),    pk(0, 0, 0, 0)};
      tbl[3] = '{"max",   pk(32767, 32767, 32767, 32767), pk(0, 0, 0, 0),
                          pk(-4, 0, 0, 0),     pk(0, 0, 0, 0)};
      tbl[4] = '{"delay1", pk(0, 1, 0, 0),     pk(0, 0, 0, 0),
                          pk(1, 0, -1, 0),     pk(0, -1, 0, 1)};
      tbl[5] = '{"min_q", pk(0, 0, 0, 0),      pk(-32768, -32768, -32768, -32768),
                          pk(0, 0, 0, 0),      pk(0, 0, 0, 0)};

      @(negedge clk);
      @(negedge clk);
      chk("reset state", 64'(stateFFT), 64'd0);
      chk("reset complete", 64'(complete), 64'd0);
      chk("reset strobe", 64'(clk_o_data), 64'd0);
      chk("reset out", 64'({data_out_i[1:0], data_out_q[1:0]}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle no valid", 64'(stateFFT), 64'd0);

      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i]);
      end

      // Held valid: a new capture every 4 cycles, identical results each time.
      @(negedge clk);
      data_in_i = tbl[0].xi;
      data_in_q = tbl[0].xq;
      valid     = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("stream state", 64'(stateFFT), 64'((c + 1) % 4));
         chk("stream complete", 64'(complete), 64'(((c % 4) >= 2) ? 1 : 0));
         chk("stream strobe", 64'(clk_o_data), 64'(((c % 4) == 2) ? 1 : 0));
         if ((c % 4) >= 2) begin
            chk("stream out_i", 64'(data_out_i), 64'(tbl[0].ei));
            chk("stream out_q", 64'(data_out_q), 64'(tbl[0].eq));
         end
      end
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset in STAGE1 clears everything at once and drops the frame.
      data_in_i = tbl[2].xi;
      data_in_q = tbl[2].xq;
      valid     = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("pre-reset state", 64'(stateFFT), 64'd1);
      chk("pre-reset out held", 64'(data_out_i), 64'(tbl[0].ei));
      #1 rst = 1'b1;
      #1;
      chk("async rst state", 64'(stateFFT), 64'd0);
      chk("async rst out_i", 64'(data_out_i), 64'd0);
      chk("async rst out_q", 64'(data_out_q), 64'd0);
      chk("async rst complete", 64'(complete), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post-reset strobe", 64'(clk_o_data), 64'd0);
         chk("post-reset state", 64'(stateFFT), 64'd0);
         chk("post-reset complete", 64'(complete), 64'd0);
      end
      run_frame(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
